// File: rtl/debug_overlay_renderer.sv
// debug_overlay_renderer: 3-stage pipelined VGA overlay that draws N = NUM_REGS+3
// labelled 16-bit hex rows (registers, PC, IR, ALU result) from per-frame shadow copies.
// Optional build macro OVERLAY_HIGHLIGHT_EN: per-row change detection and a highlight
// colour held for HOLD_FRAMES frames. Without it every lit pixel is FG_RGB.

// One overlay row: shadow value plus optional change-highlight counter.
module debug_overlay_row #(
  parameter int HOLD_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frameStart,
  input  logic [15:0] newValue,
  output logic [15:0] shadow,
  output logic        hl
);
  // Snapshot the live value once per frame so the row never tears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            shadow <= '0;
    else if (frameStart) shadow <= newValue;
  end

`ifdef OVERLAY_HIGHLIGHT_EN
  logic [7:0] holdCnt;

  // Reload on change, otherwise count down to zero once per snapshot edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    holdCnt <= '0;
    else if (frameStart) begin
      if (newValue != shadow)    holdCnt <= 8'(HOLD_FRAMES);
      else if (holdCnt != 8'd0)  holdCnt <= holdCnt - 8'd1;
    end
  end

  assign hl = |holdCnt;
`else
  assign hl = 1'b0;
`endif
endmodule

module debug_overlay_renderer #(
  parameter int          NUM_REGS    = 11,
  parameter int          X0          = 200,
  parameter int          Y0          = 80,
  parameter int          SCALE_LOG2  = 0,
  parameter logic [8:0]  FG_RGB      = 9'h1FF,
  parameter logic [8:0]  HL_RGB      = 9'h1C0,
  parameter int          HOLD_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [10:0]             x,
  input  logic [10:0]             y,
  input  logic                    frame_start,
  input  logic [16*NUM_REGS-1:0]  reg_values,
  input  logic [15:0]             pc,
  input  logic [15:0]             ir,
  input  logic [15:0]             cal_result,
  output logic [2:0]              r,
  output logic [2:0]              g,
  output logic [2:0]              b
);
  localparam int          N    = NUM_REGS + 3;
  localparam int          S    = SCALE_LOG2;
  localparam logic [10:0] X0L  = 11'(X0);
  localparam logic [10:0] Y0L  = 11'(Y0);
  localparam logic [11:0] XEND = 12'(X0 + 6 * (8 << S));
  localparam logic [11:0] YEND = 12'(Y0 + N * (16 << S));

  // 5x7 hex glyphs, row 0 in the top bits, column 0 as the MSB of each 5-bit row.
  function automatic logic [34:0] fontRom(input logic [3:0] nib);
    case (nib)
      4'h0: fontRom = 35'b11111_10001_10001_10001_10001_10001_11111;
      4'h1: fontRom = 35'b00100_01100_00100_00100_00100_00100_01110;
      4'h2: fontRom = 35'b11111_00001_00001_11111_10000_10000_11111;
      4'h3: fontRom = 35'b11111_00001_00001_11111_00001_00001_11111;
      4'h4: fontRom = 35'b10001_10001_10001_11111_00001_00001_00001;
      4'h5: fontRom = 35'b11111_10000_10000_11111_00001_00001_11111;
      4'h6: fontRom = 35'b11111_10000_10000_11111_10001_10001_11111;
      4'h7: fontRom = 35'b11111_00001_00010_00100_01000_01000_01000;
      4'h8: fontRom = 35'b11111_10001_10001_11111_10001_10001_11111;
      4'h9: fontRom = 35'b11111_10001_10001_11111_00001_00001_11111;
      4'hA: fontRom = 35'b01110_10001_10001_11111_10001_10001_10001;
      4'hB: fontRom = 35'b11110_10001_10001_11110_10001_10001_11110;
      4'hC: fontRom = 35'b11111_10000_10000_10000_10000_10000_11111;
      4'hD: fontRom = 35'b11110_10001_10001_10001_10001_10001_11110;
      4'hE: fontRom = 35'b11111_10000_10000_11110_10000_10000_11111;
      default: fontRom = 35'b11111_10000_10000_11110_10000_10000_10000;
    endcase
  endfunction

  logic [N-1:0][15:0] liveVals, shadowVals;
  logic [N-1:0]       hlRow;

  assign liveVals = {cal_result, ir, pc, reg_values};

  for (genvar i = 0; i < N; i++) begin : gRow
    debug_overlay_row #(.HOLD_FRAMES(HOLD_FRAMES)) uRow (
      .clk        (clk),
      .rst        (rst),
      .frameStart (frame_start),
      .newValue   (liveVals[i]),
      .shadow     (shadowVals[i]),
      .hl         (hlRow[i])
    );
  end

  // ---------------- S1: region test and cell coordinates ----------------
  logic [2:1]  vldPipe;
  logic        inRegion;
  logic [10:0] dx, dy;
  logic [3:0]  s1Row, s1Gy;
  logic [2:0]  s1Col, s1Gx;

  // x<X0 / y<Y0 are rejected before the wrapped offsets can matter.
  always_comb begin
    dx       = x - X0L;
    dy       = y - Y0L;
    inRegion = (x >= X0L) && ({1'b0, x} < XEND) && (y >= Y0L) && ({1'b0, y} < YEND)
               && (x < 11'd640) && (y < 11'd480);
  end

  // Register region flag, row/column and in-cell glyph coordinates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vldPipe[1] <= 1'b0;
      s1Col <= '0; s1Row <= '0; s1Gx <= '0; s1Gy <= '0;
    end else begin
      vldPipe[1] <= inRegion;
      s1Col      <= 3'(dx >> (3 + S));
      s1Row      <= 4'(dy >> (4 + S));
      s1Gx       <= 3'(dx >> S);
      s1Gy       <= 4'(dy >> S);
    end
  end

  // ---------------- S2: character select and colour select ----------------
  logic [15:0] curVal;
  logic [3:0]  selNib;
  logic        window;
  logic        s2On, s2Hl;
  logic [3:0]  s2Nib;
  logic [2:0]  s2Fx, s2Fy;

  // Column 0 is the row label (reg index, or C/D/E), column 1 blank, 2..5 the nibbles.
  always_comb begin
    curVal = shadowVals[s1Row];
    window = (s1Gx >= 3'd1) && (s1Gx <= 3'd5) && (s1Gy >= 4'd4) && (s1Gy <= 4'd10);
    selNib = 4'h0;
    case (s1Col)
      3'd0:    selNib = (s1Row < 4'(NUM_REGS)) ? s1Row : 4'(s1Row + 4'(12 - NUM_REGS));
      3'd2:    selNib = curVal[15:12];
      3'd3:    selNib = curVal[11:8];
      3'd4:    selNib = curVal[7:4];
      3'd5:    selNib = curVal[3:0];
      default: selNib = 4'h0;
    endcase
  end

  // Font coordinates are zeroed outside the glyph window to keep the ROM index in range.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vldPipe[2] <= 1'b0;
      s2On <= 1'b0; s2Hl <= 1'b0; s2Nib <= '0; s2Fx <= '0; s2Fy <= '0;
    end else begin
      vldPipe[2] <= vldPipe[1];
      s2On       <= window && (s1Col != 3'd1);
      s2Hl       <= hlRow[s1Row];
      s2Nib      <= selNib;
      s2Fx       <= window ? (s1Gx - 3'd1) : 3'd0;
      s2Fy       <= window ? 3'(s1Gy - 4'd4) : 3'd0;
    end
  end

  // ---------------- S3: font lookup and output colour ----------------
  logic [34:0] glyph;
  logic [5:0]  bitIdx;
  logic        lit;
  logic [8:0]  colour;

  always_comb begin
    glyph  = fontRom(s2Nib);
    bitIdx = 6'd34 - (6'(s2Fy) * 6'd5 + 6'(s2Fx));
    lit    = vldPipe[2] && s2On && glyph[bitIdx];
    colour = s2Hl ? HL_RGB : FG_RGB;
  end

  // Registered pixel colour; unlit and out-of-region pixels are black.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {r, g, b} <= 9'd0;
    else      {r, g, b} <= lit ? colour : 9'd0;
  end
endmodule
